// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code to key-event decoder with a show-ahead event FIFO.
// Optional typematic repeat filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_scancode_decoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW:0] ptr_t;
  typedef enum logic [2:0] {StIdle, StE0, StF0, StE0F0, StSkip} state_e;

  state_e     state_q, state_d;
  logic [2:0] skip_cnt_q, skip_cnt_d;
  logic       push_req, push_ext, push_rel, push_en;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      skip_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (code_valid) begin
      case (state_q)
        StIdle: begin
          if (code == 8'hE0) begin
            state_d = StE0;
          end else if (code == 8'hF0) begin
            state_d = StF0;
          end else if (code == 8'hE1) begin
            state_d    = StSkip;
            skip_cnt_d = 3'd7;
          end
        end
        StE0:          state_d = (code == 8'hF0) ? StE0F0 : StIdle;
        StF0, StE0F0:  state_d = StIdle;
        StSkip: begin
          skip_cnt_d = skip_cnt_q - 3'd1;
          if (skip_cnt_q == 3'd1) state_d = StIdle;
        end
        default:       state_d = StIdle;
      endcase
    end
  end

  // Event generation
  always_comb begin
    push_req = 1'b0;
    push_ext = 1'b0;
    push_rel = 1'b0;
    if (code_valid) begin
      case (state_q)
        StIdle: push_req = !(code inside {8'hE0, 8'hF0, 8'hE1, 8'h00, 8'hAA, 8'hEE,
                                          8'hFA, 8'hFC, 8'hFE, 8'hFF});
        StE0: begin
          push_req = (code != 8'hF0);
          push_ext = 1'b1;
        end
        StF0: begin
          push_req = 1'b1;
          push_rel = 1'b1;
        end
        StE0F0: begin
          push_req = 1'b1;
          push_ext = 1'b1;
          push_rel = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_valid_q, held_ext_q;
  logic [7:0] held_code_q;
  logic       held_match;

  assign held_match = held_valid_q && (held_ext_q == push_ext) && (held_code_q == code);
  // Repeated makes of the held key are typematic auto-repeat and are swallowed
  assign push_en    = push_req && !(held_match && !push_rel);

  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid_q <= 1'b0;
      held_ext_q   <= 1'b0;
      held_code_q  <= 8'h00;
    end else if (push_req) begin
      if (!push_rel && !held_match) begin
        held_valid_q <= 1'b1;
        held_ext_q   <= push_ext;
        held_code_q  <= code;
      end else if (push_rel && held_match) begin
        held_valid_q <= 1'b0;
      end
    end
  end
`else
  assign push_en = push_req;
`endif

  // Event FIFO
  logic [9:0] mem [DEPTH];
  ptr_t       wr_ptr_q, rd_ptr_q;
  logic       empty, full, do_pop, do_push;
  logic [9:0] head;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = ev_ready && !empty;
  assign do_push = push_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      if (push_en && full && !do_pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= {push_ext, push_rel, code};
  end

  assign head       = mem[rd_ptr_q[AW-1:0]];
  assign ev_valid   = !empty;
  assign ev_code    = empty ? 8'h00 : head[7:0];
  assign ev_ext     = !empty && head[9];
  assign ev_release = !empty && head[8];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder (DEPTH = 4).
// Expectations for the typematic step follow PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] code;
  logic       code_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic       ev_valid;
  logic       ev_ready;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  ps2_scancode_decoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_release (ev_release),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
  endtask

  // Head as {valid, ext, rel, code}
  task automatic chk_ev(input string tag, input logic e, input logic r, input logic [7:0] c);
    chk(tag, {5'd0, ev_valid, ev_ext, ev_release, ev_code}, {5'd0, 1'b1, e, r, c});
  endtask

  task automatic chk_empty(input string tag);
    chk(tag, {5'd0, ev_valid, ev_ext, ev_release, ev_code}, 16'h0000);
  endtask

  // Called at a negedge; strobes one byte and returns at the next negedge.
  task automatic send(input logic [7:0] b);
    code       = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    logic [7:0] refill [4];
    reset      = 1'b1;
    code       = 8'h00;
    code_valid = 1'b0;
    ev_ready   = 1'b0;
    pause_seq  = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    refill     = '{8'h1D, 8'h24, 8'h2D, 8'h3C};
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_empty("reset_head");
    chk("reset_overflow", {15'd0, overflow}, 16'd0);

    // Plain make then break, consumer always ready
    ev_ready = 1'b1;
    send(8'h1C);  chk_ev("make_1c", 1'b0, 1'b0, 8'h1C);
    send(8'hF0);  chk_empty("after_f0");
    send(8'h1C);  chk_ev("break_1c", 1'b0, 1'b1, 8'h1C);
    @(negedge clk); chk_empty("t1_drained");

    // Extended make and break
    send(8'hE0);  chk_empty("after_e0");
    send(8'h75);  chk_ev("ext_make_75", 1'b1, 1'b0, 8'h75);
    send(8'hE0);  chk_empty("after_e0_2");
    send(8'hF0);  chk_empty("after_e0f0");
    send(8'h75);  chk_ev("ext_break_75", 1'b1, 1'b1, 8'h75);
    @(negedge clk); chk_empty("t2_drained");

    // Pause sequence is swallowed, then a normal key
    for (int i = 0; i < 8; i++) begin
      send(pause_seq[i]);
      chk_empty($sformatf("pause_%0d", i));
    end
    send(8'h29);  chk_ev("post_pause_29", 1'b0, 1'b0, 8'h29);
    send(8'hAA);  chk_empty("drop_aa");
    send(8'hFA);  chk_empty("drop_fa");

    // Overflow: fill DEPTH=4 and push one more with no consumer
    ev_ready = 1'b0;
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    chk("full_no_ovf", {15'd0, overflow}, 16'd0);
    send(8'h2C);
    chk("ovf_set", {15'd0, overflow}, 16'd1);
    chk_ev("ovf_head_15", 1'b0, 1'b0, 8'h15);
    @(negedge clk);
    @(negedge clk);
    chk_ev("stable_head_15", 1'b0, 1'b0, 8'h15);
    ev_ready = 1'b1;
    @(negedge clk); chk_ev("drain_1d", 1'b0, 1'b0, 8'h1D);
    @(negedge clk); chk_ev("drain_24", 1'b0, 1'b0, 8'h24);
    @(negedge clk); chk_ev("drain_2d", 1'b0, 1'b0, 8'h2D);
    @(negedge clk); chk_empty("drain_empty");
    chk("ovf_sticky", {15'd0, overflow}, 16'd1);

    // Simultaneous push and pop while full
    ev_ready = 1'b0;
    do_reset();
    chk("ovf_cleared", {15'd0, overflow}, 16'd0);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    ev_ready = 1'b1;
    send(8'h3C);
    ev_ready = 1'b0;
    chk("pushpop_no_ovf", {15'd0, overflow}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      chk_ev($sformatf("refill_%0d", i), 1'b0, 1'b0, refill[i]);
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
    end
    chk_empty("refill_empty");

    // Reset after an E0 prefix discards the partial event
    send(8'hE0);
    do_reset();
    send(8'h1C);
    chk_ev("reset_mid_1c", 1'b0, 1'b0, 8'h1C);
    chk("reset_mid_ovf", {15'd0, overflow}, 16'd0);
    ev_ready = 1'b1;
    @(negedge clk); chk_empty("reset_mid_only_one");

    // Typematic repeats
    do_reset();
    send(8'h1C);  chk_ev("typ_first", 1'b0, 1'b0, 8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    send(8'h1C);  chk_empty("typ_rep1_suppressed");
    send(8'h1C);  chk_empty("typ_rep2_suppressed");
`else
    send(8'h1C);  chk_ev("typ_rep1", 1'b0, 1'b0, 8'h1C);
    send(8'h1C);  chk_ev("typ_rep2", 1'b0, 1'b0, 8'h1C);
`endif
    send(8'hF0);  chk_empty("typ_f0");
    send(8'h1C);  chk_ev("typ_break", 1'b0, 1'b1, 8'h1C);
    send(8'h1C);  chk_ev("typ_remake", 1'b0, 1'b0, 8'h1C);
    @(negedge clk); chk_empty("typ_drained");
    chk("typ_no_ovf", {15'd0, overflow}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
